// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Holds the frame-FSM state encoding and the data-bit count of an 8N1 frame.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy, full and empty flags.
// Pushes into a full FIFO and pops from an empty one are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_n;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_n = count;
    if (do_push && !do_pop) begin
      count_n = count + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_n = count - (AW+1)'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tells full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_n;
      full  <= (count_n == (AW+1)'(DEPTH));
      empty <= (count_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are sent LSB-first
// with one start and one stop bit, frames back-to-back with no idle gap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 50,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_wr,
  output logic                        tx_full,
  output logic                        tx_empty,
  output logic [$clog2(FIFO_DEPTH):0] tx_count,
  output logic                        overflow,
  input  logic                        ovf_clr,
  output logic                        busy,
  output logic                        uart_tx
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(UART_DATA_BITS - 1);

  uart_tx_state_t            state;
  uart_tx_state_t            state_n;
  logic [BW-1:0]             baud_cnt;
  logic [BW-1:0]             baud_n;
  logic [IW-1:0]             bit_idx;
  logic [IW-1:0]             bit_n;
  logic [UART_DATA_BITS-1:0] sh;
  logic [UART_DATA_BITS-1:0] sh_n;
  logic [7:0]                fifo_head;
  logic                      pop;
  logic                      line_n;
  logic                      baud_wrap;
  logic [BW-1:0]             baud_inc;

  // Write handshake: a byte is taken on any edge where tx_wr is high and the
  // registered tx_full is low; a write seen while tx_full is high is dropped
  // and latched into overflow.
  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_wr),
    .push_data (tx_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  assign baud_wrap = (baud_cnt == BAUD_LAST);
  assign baud_inc  = baud_wrap ? '0 : baud_cnt + BW'(1);

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    sh_n    = sh;
    pop     = 1'b0;
    line_n  = 1'b1;
    case (state)
      IDLE: begin
        if (!tx_empty) begin
          pop     = 1'b1;
          sh_n    = fifo_head;
          baud_n  = '0;
          bit_n   = '0;
          state_n = START;
        end
      end
      START: begin
        line_n = 1'b0;
        baud_n = baud_inc;
        if (baud_wrap) begin
          state_n = DATA;
        end
      end
      DATA: begin
        line_n = sh[0];
        baud_n = baud_inc;
        if (baud_wrap) begin
          sh_n  = sh >> 1;
          bit_n = bit_idx + IW'(1);
          if (bit_idx == LAST_BIT) begin
            state_n = STOP;
          end
        end
      end
      STOP: begin
        baud_n = baud_inc;
        if (baud_wrap) begin
          // Chain straight into the next frame so queued bytes leave gap-free.
          if (!tx_empty) begin
            pop     = 1'b1;
            sh_n    = fifo_head;
            bit_n   = '0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      sh       <= sh_n;
      uart_tx  <= line_n;
      busy     <= (state != IDLE);
      if (tx_wr && tx_full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
